sram_master: RTL
================

SRAM_MASTER -- requirements
Module: sram_master

Interface
REQ-001 Parameter ADDR_W, default 8, SRAM address width.
REQ-002 Parameter DATA_W, default 4, SRAM data width.
REQ-003 Parameter DEPTH, default 4, request FIFO entries (power of two, >=2).
REQ-004 Parameter RD_LAT, default 1, cycles from the read-strobe edge until sram_rdata is valid (>=1).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req_valid  input  1  host request present.
REQ-008 req_ready  output  1  request FIFO can accept.
REQ-009 req_write  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_W  request address.
REQ-011 req_wdata  input  DATA_W  write data; ignored for reads.
REQ-012 rsp_valid  output  1  one-cycle pulse, read data returned.
REQ-013 rsp_data  output  DATA_W  read data.
REQ-014 rsp_addr  output  ADDR_W  address of returned read.
REQ-015 busy  output  1  FIFO non-empty or FSM not IDLE.
REQ-016 sram_cs, sram_write, sram_read  output  1 each  SRAM strobes.
REQ-017 sram_addr  output  ADDR_W; sram_wdata  output  DATA_W; sram_rdata  input  DATA_W.

Function
REQ-018 Request accepted on rising edge with req_valid && req_ready; entry {write, addr, wdata} pushed to FIFO.
REQ-019 req_ready = FIFO not full; when full, req_ready SHALL stay low even if a pop occurs the same cycle.
REQ-020 All sram_* outputs registered; sram_cs high only in strobe cycles, with exactly one of sram_write/sram_read high.
REQ-021 Outside strobe cycles sram_cs/sram_write/sram_read = 0; sram_addr/sram_wdata hold last value.
REQ-022 FSM states: IDLE, ISSUE, RWAIT.
REQ-023 IDLE: FIFO non-empty -> pop, ISSUE; else stay.
REQ-024 ISSUE (strobe cycle S): write op -> pop next and stay ISSUE if FIFO non-empty, else IDLE; read op -> RWAIT, counter loaded with RD_LAT.
REQ-025 RWAIT: counter decrements each cycle; sram_rdata sampled at edge ending final RWAIT cycle (S+RD_LAT); then ISSUE if FIFO non-empty (pop), else IDLE.
REQ-026 Latency: accept in cycle A into empty FIFO with FSM IDLE -> strobe in A+1.
REQ-027 Writes SHALL issue back-to-back, one per cycle; a read occupies 1+RD_LAT cycles.
REQ-028 rsp_valid high for exactly cycle S+RD_LAT+1, with rsp_data = sampled sram_rdata and rsp_addr = read address; no backpressure.
REQ-029 Requests execute strictly in acceptance order; read-after-write to same address returns the new data.
REQ-030 Address has no wrap logic; ADDR_W-bit value driven unchanged (0xFF valid).
REQ-031 No response generated for writes.

Reset
REQ-032 With rst high at an edge: FSM -> IDLE, FIFO emptied, RWAIT counter cleared, in-flight read discarded.
REQ-033 Reset values: sram_cs/sram_write/sram_read/sram_addr/sram_wdata = 0, rsp_valid = 0, rsp_data = 0, rsp_addr = 0, busy = 0.
REQ-034 req_ready = 0 while rst high; = 1 in first cycle after rst deasserts.
REQ-035 rst overrides simultaneous req_valid; request in the reset cycle not accepted.

Verification
REQ-036 Reset: hold rst 2 cycles -> all outputs 0; release -> req_ready = 1, busy = 0.
REQ-037 Writes (0x01,1) accepted cycle A, (0x02,2) cycle A+1 -> strobes A+1, A+2: cs=1, write=1, addr/wdata 0x01/1 then 0x02/2; cs=0 at A+3.
REQ-038 Then read 0x01, strobe S, behavioural SRAM model -> rsp_valid only at S+2, rsp_data=1, rsp_addr=0x01; read 0x02 -> rsp_data=2.
REQ-039 Five reads offered back-to-back -> req_ready drops at FIFO full, no request lost, five responses in order, strobes spaced 2 cycles.
REQ-040 rst asserted during RWAIT -> no rsp_valid, sram_cs=0 next cycle, queued requests never issued.
REQ-041 Write (0xFF,0xF) then read 0xFF -> sram_addr=0xFF, rsp_data=0xF, rsp_addr=0xFF.

Source files
------------

// File: rtl/sram_master.sv
// sram_master: queues host read/write requests and issues them to a synchronous SRAM,
// returning read data as a one-cycle response pulse.
module sram_master #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 4,
   parameter int DEPTH  = 4,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              busy,
   output logic              sram_cs,
   output logic              sram_write,
   output logic              sram_read,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(RD_LAT + 1);
   localparam int EW = 1 + ADDR_W + DATA_W;
   typedef enum logic [1:0] {IDLE, ISSUE, RWAIT} state_t;
   state_t state, state_nxt;
   logic [EW-1:0] mem [DEPTH];
   logic [EW-1:0] head;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0] count;
   logic [CW-1:0] cnt, cnt_nxt;
   logic push, pop, avail, sample;
   assign req_ready = !rst && count != (PW+1)'(DEPTH);
   assign push = req_valid && req_ready;
   // an empty FIFO is bypassed so a request accepted while IDLE strobes the very next cycle
   assign avail = count != '0 || push;
   assign head = count != '0 ? mem[rd_ptr] : {req_write, req_addr, req_wdata};
   assign busy = count != '0 || state != IDLE;
   always_comb begin
      state_nxt = state;
      cnt_nxt = cnt;
      pop = 1'b0;
      sample = 1'b0;
      case (state)
         IDLE: begin
            pop = avail;
            state_nxt = avail ? ISSUE : IDLE;
         end
         ISSUE: begin
            pop = sram_write && avail;
            state_nxt = !sram_write ? RWAIT : avail ? ISSUE : IDLE;
            cnt_nxt = sram_write ? cnt : CW'(RD_LAT);
         end
         RWAIT: begin
            cnt_nxt = cnt - CW'(1);
            sample = cnt == CW'(1);
            pop = sample && avail;
            state_nxt = !sample ? RWAIT : avail ? ISSUE : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {req_write, req_addr, req_wdata};
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         sram_cs <= 1'b0;
         sram_write <= 1'b0;
         sram_read <= 1'b0;
         sram_addr <= '0;
         sram_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_data <= '0;
         rsp_addr <= '0;
      end else begin
         state <= state_nxt;
         cnt <= cnt_nxt;
         wr_ptr <= wr_ptr + PW'(push);
         rd_ptr <= rd_ptr + PW'(pop);
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
         sram_cs <= pop;
         sram_write <= pop && head[EW-1];
         sram_read <= pop && !head[EW-1];
         if (pop) {sram_addr, sram_wdata} <= head[EW-2:0];
         rsp_valid <= sample;
         if (sample) {rsp_data, rsp_addr} <= {sram_rdata, sram_addr};
      end
   end
endmodule
